// File: rtl/i2c_pwm_bank.sv
// i2c_pwm_bank: I2C slave exposing NUM_CH duty registers that drive glitch-free PWM LED outputs.
// Optional feature macro: I2C_READ_EN enables read transfers (R/W=1); without it reads are NACKed.
module i2c_pwm_bank #(
    parameter logic [6:0] ADDRESS  = 7'h4A,
    parameter int         NUM_CH   = 4,
    parameter int         PWM_DIV  = 15,
    parameter logic [7:0] DUTY_RST = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_i,
    output logic              scl_o,
    input  logic              sda_i,
    output logic              sda_o,
    output logic [NUM_CH-1:0] led_o
);
    localparam int          IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0]  NCH  = 8'(NUM_CH);
    localparam logic [7:0]  LAST = 8'(NUM_CH - 1);
    localparam logic [15:0] DIV  = 16'(PWM_DIV);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t      state, state_n;
    logic [2:0]  scl_s, sda_s;
    logic [7:0]  sh, sh_n, ptr, ptr_n, ptr_inc;
    logic [3:0]  bits, bits_n;
    logic        sda_n, wr_en;
    logic        scl_rise, scl_fall, start, stop, bit_in, tick, wrap;
    logic [7:0]  duty   [NUM_CH];
    logic [7:0]  shadow [NUM_CH];
    logic [15:0] pre;
    logic [7:0]  cnt;
`ifdef I2C_READ_EN
    logic        rw, rw_n;
    logic [7:0]  rd_byte;
`endif

    // No clock stretching: SCL is never pulled low.
    assign scl_o = 1'b1;

    // Edges come from the synchronised value (bit 1) against its history (bit 2).
    assign bit_in   = sda_s[1];
    assign scl_rise = scl_s[1] & ~scl_s[2];
    assign scl_fall = ~scl_s[1] & scl_s[2];
    assign start    = scl_s[1] & scl_s[2] & ~sda_s[1] & sda_s[2];
    assign stop     = scl_s[1] & scl_s[2] & sda_s[1] & ~sda_s[2];
    assign ptr_inc  = (ptr >= LAST) ? 8'h00 : ptr + 8'h01;
    assign tick     = pre == DIV;
    assign wrap     = tick && cnt == 8'hFF;
`ifdef I2C_READ_EN
    assign rd_byte  = (ptr < NCH) ? duty[ptr[IW-1:0]] : 8'h00;
`endif

    // Synchronisers and protocol state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s <= 3'b111;
            sda_s <= 3'b111;
            state <= IDLE;
            sh    <= 8'h00;
            ptr   <= 8'h00;
            bits  <= 4'd0;
            sda_o <= 1'b1;
`ifdef I2C_READ_EN
            rw    <= 1'b0;
`endif
        end else begin
            scl_s <= {scl_s[1:0], scl_i};
            sda_s <= {sda_s[1:0], sda_i};
            state <= state_n;
            sh    <= sh_n;
            ptr   <= ptr_n;
            bits  <= bits_n;
            sda_o <= sda_n;
`ifdef I2C_READ_EN
            rw    <= rw_n;
`endif
        end
    end

    // Protocol next-state: bits sampled on SCL rise, SDA changes on SCL fall.
    always_comb begin
        state_n = state;
        sh_n    = sh;
        ptr_n   = ptr;
        bits_n  = bits;
        sda_n   = sda_o;
        wr_en   = 1'b0;
`ifdef I2C_READ_EN
        rw_n    = rw;
`endif
        if (stop) begin
            state_n = IDLE;
            sda_n   = 1'b1;
        end else if (start) begin
            state_n = ADDR;
            bits_n  = 4'd0;
            sda_n   = 1'b1;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        sh_n   = {sh[6:0], bit_in};
                        bits_n = bits + 4'd1;
                    end else if (scl_fall && bits == 4'd8) begin
                        bits_n  = 4'd0;
`ifdef I2C_READ_EN
                        rw_n    = sh[0];
                        state_n = (sh[7:1] == ADDRESS) ? ADDR_ACK : IDLE;
                        sda_n   = sh[7:1] != ADDRESS;
`else
                        state_n = (sh[7:1] == ADDRESS && !sh[0]) ? ADDR_ACK : IDLE;
                        sda_n   = !(sh[7:1] == ADDRESS && !sh[0]);
`endif
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_n   = 1'b1;
                        bits_n  = 4'd0;
                        state_n = PTR;
`ifdef I2C_READ_EN
                        if (rw) begin
                            state_n = RDATA;
                            sda_n   = rd_byte[7];
                            sh_n    = {rd_byte[6:0], 1'b0};
                            bits_n  = 4'd1;
                        end
`endif
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        sh_n   = {sh[6:0], bit_in};
                        bits_n = bits + 4'd1;
                    end else if (scl_fall && bits == 4'd8) begin
                        ptr_n   = sh;
                        sda_n   = 1'b0;
                        bits_n  = 4'd0;
                        state_n = PTR_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_n   = 1'b1;
                        bits_n  = 4'd0;
                        state_n = WDATA;
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        sh_n   = {sh[6:0], bit_in};
                        bits_n = bits + 4'd1;
                    end else if (scl_fall && bits == 4'd8) begin
                        wr_en   = ptr < NCH;
                        ptr_n   = ptr_inc;
                        sda_n   = 1'b0;
                        bits_n  = 4'd0;
                        state_n = WDATA_ACK;
                    end
                end
`ifdef I2C_READ_EN
                RDATA: begin
                    if (scl_fall) begin
                        if (bits == 4'd0) begin
                            sda_n  = rd_byte[7];
                            sh_n   = {rd_byte[6:0], 1'b0};
                            bits_n = 4'd1;
                        end else if (bits == 4'd8) begin
                            sda_n   = 1'b1;
                            bits_n  = 4'd0;
                            state_n = RDATA_ACK;
                        end else begin
                            sda_n  = sh[7];
                            sh_n   = {sh[6:0], 1'b0};
                            bits_n = bits + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        state_n = bit_in ? IDLE : RDATA;
                        ptr_n   = bit_in ? ptr : ptr_inc;
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Duty registers written from the received byte at the end of a data byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) duty[i] <= DUTY_RST;
            else if (wr_en && ptr[IW-1:0] == IW'(i)) duty[i] <= sh;
        end
    end

    // PWM timebase; shadows reload only at counter wrap so a period never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre   <= 16'd0;
            cnt   <= 8'd0;
            led_o <= '0;
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= DUTY_RST;
        end else begin
            pre <= tick ? 16'd0 : pre + 16'd1;
            if (tick) cnt <= cnt + 8'd1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wrap) shadow[i] <= duty[i];
                led_o[i] <= cnt < shadow[i];
            end
        end
    end
endmodule

// File: tb/tb_i2c_pwm_bank.sv
// tb_i2c_pwm_bank: directed I2C transfers with a scoreboard for ACK/read bits and PWM duty counts.
`timescale 1ns/1ps
module tb_i2c_pwm_bank;
    localparam int Q = 8;

    typedef struct {
        string      name;
        logic [7:0] val;
        int         nbits;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_o, sda_o, sda_bus;
    logic [3:0] led_o;
    exp_t       exp_q[$];
    event       slot;
    int         vectors = 0;
    int         errors = 0;
    bit         watch_hi = 1'b0;
    bit         saw_low = 1'b0;
    logic [7:0] mon_got;
    int         mon_nb;

    assign sda_bus = sda_m & sda_o;

    i2c_pwm_bank #(.PWM_DIV(3)) dut (
        .clk   (clk),
        .reset (reset),
        .scl_i (scl_m),
        .scl_o (scl_o),
        .sda_i (sda_bus),
        .sda_o (sda_o),
        .led_o (led_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_resp(input string name, input logic [7:0] val, input int nbits);
        exp_t e;
        e.name  = name;
        e.val   = val;
        e.nbits = nbits;
        exp_q.push_back(e);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; cyc(Q);
            scl_m = 1'b1; cyc(Q);
            scl_m = 1'b0; cyc(Q);
        end
    endtask

    task automatic write_byte(input string name, input logic [7:0] b, input logic ack_exp);
        send_bits(b, 8);
        sda_m = 1'b1;
        expect_resp(name, {7'b0, ack_exp}, 1);
        cyc(Q);
        scl_m = 1'b1; cyc(Q / 2);
        -> slot;
        cyc(Q / 2);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic read_byte(input string name, input logic [7:0] val, input logic master_ack);
        sda_m = 1'b1;
        expect_resp(name, val, 8);
        for (int i = 0; i < 8; i++) begin
            scl_m = 1'b1; cyc(Q / 2);
            -> slot;
            cyc(Q / 2);
            scl_m = 1'b0; cyc(Q);
        end
        sda_m = !master_ack; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        scl_m = 1'b0; cyc(Q);
        sda_m = 1'b1;
    endtask

    task automatic measure(input string tag, input int e [4]);
        int hi [4];
        for (int i = 0; i < 4; i++) hi[i] = 0;
        cyc(1100);
        repeat (1024) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) hi[i] += int'(led_o[i]);
        end
        for (int i = 0; i < 4; i++) check($sformatf("%s pwm ch%0d", tag, i), 32'(hi[i]), 32'(e[i]));
    endtask

    // Monitor: collects bits the DUT drives in each slave slot and compares against the queue head.
    initial begin
        mon_got = 8'h00;
        mon_nb  = 0;
        forever begin
            @(slot);
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected slot: got sda_o=%0b, expected no response", sda_o);
            end else begin
                mon_got = {mon_got[6:0], sda_o};
                mon_nb++;
                if (mon_nb == exp_q[0].nbits) begin
                    check(exp_q[0].name, 32'(mon_got), 32'(exp_q[0].val));
                    void'(exp_q.pop_front());
                    mon_got = 8'h00;
                    mon_nb  = 0;
                end
            end
        end
    end

    // Sticky detector for any SDA pull-down while a window is watched.
    always @(negedge clk) if (watch_hi && !sda_o) saw_low = 1'b1;

    initial begin
        cyc(90000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        cyc(2);
        reset = 1'b0;
        cyc(1);
        check("reset led_o", 32'(led_o), 32'h0);
        check("reset sda_o", 32'(sda_o), 32'h1);
        check("reset scl_o", 32'(scl_o), 32'h1);
        measure("reset", '{0, 0, 0, 0});
`ifdef I2C_READ_EN
        i2c_start();
        write_byte("rst addr ack", 8'h94, 1'b0);
        write_byte("rst ptr ack", 8'h00, 1'b0);
        i2c_start();
        write_byte("rst raddr ack", 8'h95, 1'b0);
        read_byte("rst duty0", 8'h00, 1'b1);
        read_byte("rst duty1", 8'h00, 1'b1);
        read_byte("rst duty2", 8'h00, 1'b1);
        read_byte("rst duty3", 8'h00, 1'b0);
        i2c_stop();
`endif
        i2c_start();
        write_byte("wr addr ack", 8'h94, 1'b0);
        write_byte("wr ptr ack", 8'h01, 1'b0);
        write_byte("wr data ack", 8'h80, 1'b0);
        i2c_stop();
        measure("write", '{0, 512, 0, 0});

        i2c_start();
        write_byte("inc addr ack", 8'h94, 1'b0);
        write_byte("inc ptr ack", 8'h03, 1'b0);
        write_byte("inc d3 ack", 8'h11, 1'b0);
        write_byte("inc d0 ack", 8'h22, 1'b0);
        i2c_stop();
        measure("autoinc", '{136, 512, 0, 68});

        watch_hi = 1'b1;
        saw_low  = 1'b0;
        i2c_start();
        write_byte("mismatch addr nack", 8'h96, 1'b1);
        write_byte("mismatch b1 nack", 8'h01, 1'b1);
        write_byte("mismatch b2 nack", 8'h55, 1'b1);
        i2c_stop();
        watch_hi = 1'b0;
        check("mismatch sda low seen", 32'(saw_low), 32'h0);
        measure("mismatch", '{136, 512, 0, 68});

        i2c_start();
        write_byte("rd wr addr ack", 8'h94, 1'b0);
        write_byte("rd ptr ack", 8'h01, 1'b0);
        i2c_start();
`ifdef I2C_READ_EN
        write_byte("rd addr ack", 8'h95, 1'b0);
        read_byte("rd duty1", 8'h80, 1'b1);
        read_byte("rd duty2", 8'h00, 1'b0);
`else
        write_byte("rd addr nack", 8'h95, 1'b1);
`endif
        i2c_stop();

        i2c_start();
        write_byte("oor addr ack", 8'h94, 1'b0);
        write_byte("oor ptr ack", 8'h07, 1'b0);
        write_byte("oor data ack", 8'h55, 1'b0);
        i2c_stop();
        measure("out of range", '{136, 512, 0, 68});

        i2c_start();
        write_byte("abort addr ack", 8'h94, 1'b0);
        send_bits(8'h00, 8);
        sda_m = 1'b1;
        check("abort ack low", 32'(sda_o), 32'h0);
        reset = 1'b1;
        cyc(1);
        check("abort sda released", 32'(sda_o), 32'h1);
        cyc(1);
        reset = 1'b0;
        cyc(Q);
        scl_m = 1'b1; cyc(Q);
        scl_m = 1'b0; cyc(Q);
        write_byte("abort ignored b1", 8'h03, 1'b1);
        write_byte("abort ignored b2", 8'hFF, 1'b1);
        i2c_stop();
        measure("abort", '{0, 0, 0, 0});

        i2c_start();
        write_byte("post addr ack", 8'h94, 1'b0);
        write_byte("post ptr ack", 8'h02, 1'b0);
        write_byte("post data ack", 8'h40, 1'b0);
        i2c_stop();
        measure("post abort", '{0, 0, 256, 0});

        cyc(Q);
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
